// File: rtl/matmul_pkg.sv
// Shared types for the matrix-multiply job front-end: PE command codes, completion status,
// job descriptor and the dispatcher state encoding.
package matmul_pkg;

    typedef enum logic [1:0] {
        PE_IDLE  = 2'b00,
        PE_START = 2'b01,
        PE_RUN   = 2'b10,
        PE_ABORT = 2'b11
    } pe_cmd_t;

    typedef enum logic [1:0] {
        OK           = 2'b00,
        BAD_DIM      = 2'b01,
        OUT_OF_RANGE = 2'b10,
        TIMEOUT      = 2'b11
    } job_status_t;

    typedef struct packed {
        logic [31:0] m;
        logic [31:0] n;
        logic [31:0] p;
        logic [31:0] left_off;
        logic [31:0] right_off;
        logic [31:0] result_off;
    } job_desc_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_START,
        ST_RUN,
        ST_ABORT,
        ST_DONE
    } disp_state_t;

    // One-past-last word of a rows x cols region; 64 bits so neither product nor sum wraps.
    function automatic logic [63:0] region_end(input logic [31:0] off,
                                               input logic [31:0] rows,
                                               input logic [31:0] cols);
        return 64'(off) + 64'(rows) * 64'(cols);
    endfunction

endpackage

// File: rtl/matmul_bounds_check.sv
// Combinational descriptor validation: zero dimensions first, then every matrix region
// must end at or below RAM_SIZE.
module matmul_bounds_check
    import matmul_pkg::*;
#(
    parameter int unsigned RAM_SIZE = 1024
) (
    input  job_desc_t   desc,
    output job_status_t status
);

    localparam logic [63:0] RAM_LIMIT = 64'(RAM_SIZE);

    logic [63:0] left_end;
    logic [63:0] right_end;
    logic [63:0] result_end;

    assign left_end   = region_end(desc.left_off,   desc.m, desc.n);
    assign right_end  = region_end(desc.right_off,  desc.n, desc.p);
    assign result_end = region_end(desc.result_off, desc.m, desc.p);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        status = OK;
        if (desc.m == '0 || desc.n == '0 || desc.p == '0) begin
            status = BAD_DIM;
        end else if (left_end > RAM_LIMIT || right_end > RAM_LIMIT || result_end > RAM_LIMIT) begin
            status = OUT_OF_RANGE;
        end
    end

endmodule

// File: rtl/matmul_dispatcher.sv
// Job front-end for the PE array: accepts one descriptor, validates it, drives the per-PE
// start code through START/RUN/ABORT, gathers per-PE done and returns a completion record.
module matmul_dispatcher
    import matmul_pkg::*;
#(
    parameter int PE_COUNT = 4,
    parameter int RAM_SIZE = 1024,
    parameter int TIMEOUT  = 65535
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     job_valid,
    output logic                     job_ready,
    input  logic [31:0]              job_m,
    input  logic [31:0]              job_n,
    input  logic [31:0]              job_p,
    input  logic [31:0]              job_left_off,
    input  logic [31:0]              job_right_off,
    input  logic [31:0]              job_result_off,
    output logic [31:0]              M,
    output logic [31:0]              N,
    output logic [31:0]              P,
    output logic [31:0]              left_offset,
    output logic [31:0]              right_offset,
    output logic [31:0]              result_offset,
    output logic [PE_COUNT-1:0][1:0] start_signal,
    input  logic [PE_COUNT-1:0]      pe_done,
    output logic                     busy,
    output logic                     done_valid,
    input  logic                     done_ready,
    output logic [1:0]               done_status,
    output logic [31:0]              done_cycles
);

    localparam logic [31:0] TIMEOUT_LIMIT = 32'(TIMEOUT);

    disp_state_t          state_q, state_d;
    job_desc_t            job_in, desc_q;
    job_status_t          chk_status, status_q;
    pe_cmd_t              start_code;
    logic [PE_COUNT-1:0]  mask_q, mask_next;
    logic [31:0]          cnt_q, cnt_inc;
    logic                 mask_full;
    logic                 timeout_hit;

    assign job_in = '{m: job_m, n: job_n, p: job_p, left_off: job_left_off,
                      right_off: job_right_off, result_off: job_result_off};

    matmul_bounds_check #(
        .RAM_SIZE (RAM_SIZE)
    ) u_bounds (
        .desc   (desc_q),
        .status (chk_status)
    );

    assign mask_next   = mask_q | pe_done;
    assign mask_full   = &mask_next;
    assign cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + 32'd1;
    assign timeout_hit = cnt_inc >= TIMEOUT_LIMIT;

    always_comb begin
        state_d    = state_q;
        start_code = PE_IDLE;
        unique case (state_q)
            ST_IDLE:  if (job_valid) state_d = ST_CHECK;
            ST_CHECK: state_d = (chk_status == OK) ? ST_START : ST_DONE;
            ST_START: begin
                start_code = PE_START;
                state_d    = ST_RUN;
            end
            ST_RUN: begin
                start_code = PE_RUN;
                // Completion is tested before the timeout so a same-cycle finish reports OK.
                if (mask_full)        state_d = ST_DONE;
                else if (timeout_hit) state_d = ST_ABORT;
            end
            ST_ABORT: begin
                start_code = PE_ABORT;
                state_d    = ST_DONE;
            end
            ST_DONE:  if (done_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            desc_q   <= '0;
            mask_q   <= '0;
            cnt_q    <= '0;
            status_q <= OK;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (job_valid) begin
                        desc_q <= job_in;
                        cnt_q  <= '0;
                    end
                end
                ST_CHECK: status_q <= chk_status;
                ST_START: begin
                    // Fresh mask per job, but a done pulse already present in START counts.
                    mask_q <= pe_done;
                    cnt_q  <= 32'd1;
                end
                ST_RUN: begin
                    mask_q <= mask_next;
                    cnt_q  <= cnt_inc;
                end
                ST_ABORT: status_q <= matmul_pkg::TIMEOUT;
                default: ;
            endcase
        end
    end

    assign job_ready     = (state_q == ST_IDLE);
    assign busy          = (state_q != ST_IDLE);
    assign done_valid    = (state_q == ST_DONE);
    assign done_status   = status_q;
    assign done_cycles   = cnt_q;
    assign start_signal  = {PE_COUNT{start_code}};

    assign M             = desc_q.m;
    assign N             = desc_q.n;
    assign P             = desc_q.p;
    assign left_offset   = desc_q.left_off;
    assign right_offset  = desc_q.right_off;
    assign result_offset = desc_q.result_off;

endmodule

// File: tb/tb_matmul_dispatcher.sv
// Directed bench for matmul_dispatcher (PE_COUNT=4, RAM_SIZE=1024, TIMEOUT=10): a vector
// table of descriptors with expected records, plus hand sequences for back-pressure and reset.
module tb_matmul_dispatcher;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              job_valid = 1'b0;
    logic              job_ready;
    logic [31:0]       job_m = '0, job_n = '0, job_p = '0;
    logic [31:0]       job_left_off = '0, job_right_off = '0, job_result_off = '0;
    logic [31:0]       M, N, P, left_offset, right_offset, result_offset;
    logic [3:0][1:0]   start_signal;
    logic [3:0]        pe_done = '0;
    logic              busy;
    logic              done_valid;
    logic              done_ready = 1'b0;
    logic [1:0]        done_status;
    logic [31:0]       done_cycles;

    int n_total = 0;
    int n_pass  = 0;

    // dly[i]: RUN-cycle index (0 = first RUN cycle) at which PE i pulses done;
    // 8'hFE = pulse during START, 8'hFF = never.
    typedef struct {
        string           name;
        logic [31:0]     m, n, p, lo, ro, so;
        logic [3:0][7:0] dly;
        logic [1:0]      st;
        logic [31:0]     cyc;
        int              starts;
        int              aborts;
    } vec_t;

    vec_t vecs [12];

    matmul_dispatcher #(
        .PE_COUNT (4),
        .RAM_SIZE (1024),
        .TIMEOUT  (10)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .job_valid      (job_valid),
        .job_ready      (job_ready),
        .job_m          (job_m),
        .job_n          (job_n),
        .job_p          (job_p),
        .job_left_off   (job_left_off),
        .job_right_off  (job_right_off),
        .job_result_off (job_result_off),
        .M              (M),
        .N              (N),
        .P              (P),
        .left_offset    (left_offset),
        .right_offset   (right_offset),
        .result_offset  (result_offset),
        .start_signal   (start_signal),
        .pe_done        (pe_done),
        .busy           (busy),
        .done_valid     (done_valid),
        .done_ready     (done_ready),
        .done_status    (done_status),
        .done_cycles    (done_cycles)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    function automatic vec_t mk(input string nm, input logic [31:0] m, n, p, lo, ro, so,
                                input logic [31:0] dly, input logic [1:0] st,
                                input logic [31:0] cyc, input int starts, input int aborts);
        vec_t v;
        v.name = nm; v.m = m; v.n = n; v.p = p; v.lo = lo; v.ro = ro; v.so = so;
        v.dly = dly; v.st = st; v.cyc = cyc; v.starts = starts; v.aborts = aborts;
        return v;
    endfunction

    // Drives the descriptor for one accept edge (DUT must be idle), then scrambles the inputs.
    task automatic present(input vec_t v);
        @(negedge clk);
        check({v.name, ".ready"}, 64'(job_ready), 64'd1);
        job_m = v.m; job_n = v.n; job_p = v.p;
        job_left_off = v.lo; job_right_off = v.ro; job_result_off = v.so;
        job_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        job_valid = 1'b0;
        job_m = 32'hDEAD_0001; job_n = 32'hDEAD_0002; job_p = 32'hDEAD_0003;
        job_left_off = 32'hBEEF_0001; job_right_off = 32'hBEEF_0002; job_result_off = 32'hBEEF_0003;
        check({v.name, ".busy"}, 64'(busy), 64'd1);
    endtask

    // Plays the PE side until done_valid, counting the codes seen on start_signal.
    task automatic run_to_done(input vec_t v, output int ns, output int nr, output int na,
                               output int nx, output logic ok);
        int ridx;
        logic [1:0] code;
        ridx = 0; ns = 0; nr = 0; na = 0; nx = 0; ok = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            pe_done = '0;
            if (done_valid) begin
                ok = 1'b1;
                return;
            end
            code = start_signal[0];
            if (start_signal != {4{code}}) nx++;
            case (code)
                2'b01: begin
                    ns++;
                    for (int i = 0; i < 4; i++) if (v.dly[i] == 8'hFE) pe_done[i] = 1'b1;
                end
                2'b10: begin
                    nr++;
                    for (int i = 0; i < 4; i++) if (32'(v.dly[i]) == ridx) pe_done[i] = 1'b1;
                    ridx++;
                end
                2'b11: na++;
                default: ;
            endcase
        end
    endtask

    task automatic check_record(input vec_t v, input int ns, input int nr, input int na,
                                input int nx, input logic ok);
        check({v.name, ".wait_done"}, 64'(ok), 64'd1);
        check({v.name, ".status"}, 64'(done_status), 64'(v.st));
        check({v.name, ".cycles"}, 64'(done_cycles), 64'(v.cyc));
        check({v.name, ".starts"}, 64'(ns), 64'(v.starts));
        check({v.name, ".runs"}, 64'(nr), (v.starts == 1) ? 64'(v.cyc - 1) : 64'd0);
        check({v.name, ".aborts"}, 64'(na), 64'(v.aborts));
        check({v.name, ".lanes"}, 64'(nx), 64'd0);
        check({v.name, ".mn"}, {M, N}, {v.m, v.n});
        check({v.name, ".p_res"}, {P, result_offset}, {v.p, v.so});
        check({v.name, ".lr"}, {left_offset, right_offset}, {v.lo, v.ro});
        check({v.name, ".done_ready_low"}, 64'(job_ready), 64'd0);
    endtask

    task automatic handshake(input string name);
        done_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        done_ready = 1'b0;
        check({name, ".post_valid"}, 64'(done_valid), 64'd0);
        check({name, ".post_busy"}, 64'(busy), 64'd0);
        check({name, ".post_ready"}, 64'(job_ready), 64'd1);
    endtask

    initial begin
        int   ns, nr, na, nx;
        logic ok;

        vecs[0]  = mk("ok_4x4",      4, 4, 4, 0, 16, 32,          32'h06050403, 2'd0, 8,  1, 0);
        vecs[1]  = mk("bad_n0",      4, 0, 4, 0, 16, 32,          32'hFFFFFFFF, 2'd1, 0,  0, 0);
        vecs[2]  = mk("oor_result",  16, 16, 16, 0, 256, 1000,    32'hFFFFFFFF, 2'd2, 0,  0, 0);
        vecs[3]  = mk("timeout",     4, 4, 4, 0, 16, 32,          32'hFF050403, 2'd3, 10, 1, 1);
        vecs[4]  = mk("edge_1024",   4, 4, 4, 1008, 1008, 1008,   32'h06050403, 2'd0, 8,  1, 0);
        vecs[5]  = mk("edge_1025",   4, 4, 4, 0, 0, 1009,         32'hFFFFFFFF, 2'd2, 0,  0, 0);
        vecs[6]  = mk("bad_prio",    0, 4, 4, 32'hFFFFFFF0, 0, 0, 32'hFFFFFFFF, 2'd1, 0,  0, 0);
        vecs[7]  = mk("wide_prod",   32'h10000, 32'h10000, 32'h10000, 0, 0, 0,
                                                                  32'hFFFFFFFF, 2'd2, 0,  0, 0);
        vecs[8]  = mk("start_done",  4, 4, 4, 0, 16, 32,          32'hFEFEFEFE, 2'd0, 2,  1, 0);
        vecs[9]  = mk("fast",        4, 4, 4, 0, 16, 32,          32'h00000001, 2'd0, 3,  1, 0);
        vecs[10] = mk("ok_at_limit", 4, 4, 4, 0, 16, 32,          32'h08000000, 2'd0, 10, 1, 0);
        vecs[11] = mk("late_by_one", 4, 4, 4, 0, 16, 32,          32'h09000000, 2'd3, 10, 1, 1);

        // Reset values, first while held and then after release.
        #12;
        check("rst.start_signal", 64'(start_signal), 64'd0);
        check("rst.busy", 64'(busy), 64'd0);
        check("rst.done_valid", 64'(done_valid), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst.job_ready", 64'(job_ready), 64'd1);
        check("rst.mnp", {M, N}, 64'd0);
        check("rst.offs", {P, left_offset}, 64'd0);
        check("rst.offs2", {right_offset, result_offset}, 64'd0);
        check("rst.record", {30'd0, done_status, done_cycles}, 64'd0);

        foreach (vecs[k]) begin
            present(vecs[k]);
            run_to_done(vecs[k], ns, nr, na, nx, ok);
            check_record(vecs[k], ns, nr, na, nx, ok);
            handshake(vecs[k].name);
        end

        // Back-pressure: record holds for 5 cycles, early descriptor waits for the handshake.
        present(vecs[0]);
        run_to_done(vecs[0], ns, nr, na, nx, ok);
        check("hold.wait_done", 64'(ok), 64'd1);
        job_m = vecs[6].m; job_n = vecs[6].n; job_p = vecs[6].p;
        job_left_off = vecs[6].lo; job_right_off = vecs[6].ro; job_result_off = vecs[6].so;
        job_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check("hold.valid", 64'(done_valid), 64'd1);
            check("hold.record", {30'd0, done_status, done_cycles}, {30'd0, 2'd0, 32'd8});
            check("hold.job_ready", 64'(job_ready), 64'd0);
            @(negedge clk);
        end
        done_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        done_ready = 1'b0;
        check("hold.idle_busy", 64'(busy), 64'd0);
        check("hold.idle_ready", 64'(job_ready), 64'd1);
        check("hold.old_m", 64'(M), 64'd4);
        @(posedge clk);
        @(negedge clk);
        job_valid = 1'b0;
        check("hold.accept_busy", 64'(busy), 64'd1);
        check("hold.new_m", {M, left_offset}, {32'd0, 32'hFFFFFFF0});
        run_to_done(vecs[6], ns, nr, na, nx, ok);
        check_record(vecs[6], ns, nr, na, nx, ok);
        handshake("hold.second");

        // Reset dropped during RUN, then a clean job with a stray done pulse in CHECK.
        present(vecs[0]);
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            if (start_signal[0] == 2'b10) ok = 1'b1;
        end
        check("mid_rst.reached_run", 64'(ok), 64'd1);
        pe_done = 4'b0111;
        @(negedge clk);
        pe_done = '0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst.start_signal", 64'(start_signal), 64'd0);
        check("mid_rst.busy", 64'(busy), 64'd0);
        check("mid_rst.done_valid", 64'(done_valid), 64'd0);
        check("mid_rst.m", 64'(M), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst.job_ready", 64'(job_ready), 64'd1);
        present(vecs[0]);
        pe_done = 4'b1111;
        run_to_done(vecs[0], ns, nr, na, nx, ok);
        check_record(vecs[0], ns, nr, na, nx, ok);
        handshake("mid_rst.after");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
